// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: default PC width and the next-PC source encoding
// used by both the program counter and the decoder.
package picomips_pkg;

  localparam int PC_W = 6;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_REL  = 3'd2,
    PC_ABS  = 3'd3,
    PC_RST  = 3'd4
  } pc_src_e;

endpackage : picomips_pkg

// File: rtl/pc_next.sv
// Next-PC logic: resolves the fixed-priority control set to a source, then
// forms the next address with a single modulo-2^p adder and a mux.
module pc_next
  import picomips_pkg::*;
#(
  parameter int p = PC_W
) (
  input  logic         reset,
  input  logic         pc_incr,
  input  logic         pc_abs,
  input  logic         pc_rel,
  input  logic [p-1:0] pc_q,
  input  logic [p-1:0] branch_addr,
  output pc_src_e      pc_src_o,
  output logic [p-1:0] pc_d
);

  logic [p-1:0] addend;
  logic [p-1:0] sum;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    pc_src_o = PC_HOLD;
    if (reset)        pc_src_o = PC_RST;
    else if (pc_abs)  pc_src_o = PC_ABS;
    else if (pc_rel)  pc_src_o = PC_REL;
    else if (pc_incr) pc_src_o = PC_INC;
  end

  // The signed offset is simply added at width p; two's-complement wrap makes
  // backward branches fall out for free, and the carry is discarded.
  always_comb begin
    addend = '0;
    if (pc_src_o == PC_REL) addend = branch_addr;
    else if (pc_src_o == PC_INC) addend = p'(1);
  end

  assign sum = pc_q + addend;

  always_comb begin
    pc_d = pc_q;
    case (pc_src_o)
      PC_RST:  pc_d = '0;
      PC_ABS:  pc_d = branch_addr;
      PC_REL,
      PC_INC:  pc_d = sum;
      default: pc_d = pc_q;
    endcase
  end

endmodule : pc_next

// File: rtl/pc_unit.sv
// picoMIPS program counter: one p-bit register fed by pc_next, with a
// synchronous active-high reset. pcout comes straight from the register.
module pc_unit
  import picomips_pkg::*;
#(
  parameter int p = PC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pc_incr,
  input  logic         pc_abs,
  input  logic         pc_rel,
  input  logic [p-1:0] branch_addr,
  output logic [p-1:0] pcout
);

  logic [p-1:0] pc_q;
  logic [p-1:0] pc_d;
  pc_src_e      pc_src;

  pc_next #(.p(p)) u_pc_next (
    .reset       (reset),
    .pc_incr     (pc_incr),
    .pc_abs      (pc_abs),
    .pc_rel      (pc_rel),
    .pc_q        (pc_q),
    .branch_addr (branch_addr),
    .pc_src_o    (pc_src),
    .pc_d        (pc_d)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pcout = pc_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit at p = 6: reset, increment, relative
// and absolute branches, control priority, wrap-around and reset override.
module tb_pc_unit;

  localparam int P = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         pc_incr;
  logic         pc_abs;
  logic         pc_rel;
  logic [P-1:0] branch_addr;
  logic [P-1:0] pcout;

  int total = 0;
  int bad   = 0;

  pc_unit #(.p(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_incr     (pc_incr),
    .pc_abs      (pc_abs),
    .pc_rel      (pc_rel),
    .branch_addr (branch_addr),
    .pcout       (pcout)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic inc, input logic abs_b,
                       input logic rel_b, input logic [P-1:0] ba);
    reset       = rst;
    pc_incr     = inc;
    pc_abs      = abs_b;
    pc_rel      = rel_b;
    branch_addr = ba;
  endtask

  // Advance one rising edge, then compare pcout 1 time unit later.
  task automatic step_check(input string tag, input logic [P-1:0] exp);
    @(posedge clk);
    #1;
    total++;
    assert (pcout === exp)
    else begin
      bad++;
      $error("FAIL %s: pcout=%0d expected=%0d", tag, pcout, exp);
    end
  endtask

  initial begin
    // reset held two edges, then released with idle controls
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    step_check("reset_edge1", 6'd0);
    step_check("reset_edge2", 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    step_check("idle_after_reset", 6'd0);

    // sequential increment, then hold
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    step_check("incr_1", 6'd1);
    step_check("incr_2", 6'd2);
    step_check("incr_3", 6'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    step_check("hold_3", 6'd3);

    // relative branches from 5: forward +3, then backward -2
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd5);
    step_check("abs_to_5", 6'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd3);
    step_check("rel_fwd_8", 6'd8);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'b111110);
    step_check("rel_back_6", 6'd6);

    // absolute branch and priority with all controls together
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd2);
    step_check("abs_2", 6'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd9);
    step_check("abs_wins_9", 6'd9);

    // wrap: 63 + 1 -> 0
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd63);
    step_check("abs_63", 6'd63);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    step_check("incr_wrap_0", 6'd0);

    // wrap: 62 + 3 -> 1
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd62);
    step_check("abs_62", 6'd62);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd3);
    step_check("rel_wrap_1", 6'd1);

    // wrap: 0 - 1 -> 63
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    step_check("abs_0", 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'b111111);
    step_check("rel_wrap_63", 6'd63);

    // relative beats increment: 63 + 2 -> 1, not 0
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd2);
    step_check("rel_over_incr", 6'd1);

    // reset overrides a simultaneous absolute branch and holds at 0
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd20);
    step_check("abs_20", 6'd20);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd20);
    step_check("reset_over_abs", 6'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd7);
    step_check("reset_hold_1", 6'd0);
    step_check("reset_hold_2", 6'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    step_check("incr_after_reset", 6'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_unit
